regfile_scoreboard: RTL and testbench

- 32 x 64-bit integer register file and pending-write scoreboard for the 64-bit RISC-V core.
- Consumes the writeback stage output (64-bit write data plus destination index and enable) and serves both decode source reads.
- Tracks in-flight writes per destination register and stalls issue on RAW hazards and pending-count overflow.
- Write-to-read bypass in the writeback cycle; x0 hardwired to zero.

---
 rtl/regfile_scoreboard.sv | 118 +++++++++++
 tb/tb_regfile_scoreboard.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// 32 x XLEN integer register file with a per-register pending-write scoreboard.
// Serves two combinational decode reads with writeback bypass and gates issue on RAW/overflow hazards.
module regfile_scoreboard #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            issue_wen,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  output logic            issue_ready,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [31:0]     busy_mask
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0]  r_regs [32];
  logic [CNT_W-1:0] r_cnt  [32];
  logic             r_busy [32];

  logic             w_fire;
  logic             w_src1_hz;
  logic             w_src2_hz;
  logic             w_ovf;
  logic [CNT_W-1:0] w_cnt_rs1;
  logic [CNT_W-1:0] w_cnt_rs2;
  logic [CNT_W-1:0] w_cnt_rd;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi = gi + 1) begin : g_entry
      if (gi == 0) begin : g_x0
        always_ff @(posedge clk) begin
          r_regs[gi] <= '0;
          r_cnt[gi]  <= '0;
          r_busy[gi] <= 1'b0;
        end
      end else begin : g_reg
        logic             w_wr;
        logic             w_inc;
        logic             w_dec;
        logic [CNT_W-1:0] w_cnt_next;

        // Matching increment and decrement on one register cancel out.
        always_comb begin
          w_wr       = wb_en && (wb_rd == 5'(gi));
          w_inc      = w_fire && issue_wen && (issue_rd == 5'(gi));
          w_dec      = w_wr && (r_cnt[gi] != '0);
          w_cnt_next = r_cnt[gi];
          if (w_inc && !w_dec) begin
            w_cnt_next = r_cnt[gi] + CNT_ONE;
          end else if (w_dec && !w_inc) begin
            w_cnt_next = r_cnt[gi] - CNT_ONE;
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            r_regs[gi] <= '0;
            r_cnt[gi]  <= '0;
            r_busy[gi] <= 1'b0;
          end else begin
            if (w_wr) begin
              r_regs[gi] <= wb_data;
            end
            r_cnt[gi]  <= w_cnt_next;
            r_busy[gi] <= (w_cnt_next != '0);
          end
        end
      end

      assign busy_mask[gi] = r_busy[gi];
    end
  endgenerate

  always_comb begin
    rs1_data = r_regs[rs1_addr];
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (wb_en && (wb_rd == rs1_addr)) begin
      rs1_data = wb_data;
    end
    rs2_data = r_regs[rs2_addr];
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (wb_en && (wb_rd == rs2_addr)) begin
      rs2_data = wb_data;
    end
  end

  // A source whose last outstanding write retires this cycle is already safe via the bypass.
  always_comb begin
    w_cnt_rs1 = r_cnt[rs1_addr];
    w_cnt_rs2 = r_cnt[rs2_addr];
    w_cnt_rd  = r_cnt[issue_rd];
    w_src1_hz = issue_use_rs1 && (rs1_addr != 5'd0) && (w_cnt_rs1 != '0) &&
                !(wb_en && (wb_rd == rs1_addr) && (w_cnt_rs1 == CNT_ONE));
    w_src2_hz = issue_use_rs2 && (rs2_addr != 5'd0) && (w_cnt_rs2 != '0) &&
                !(wb_en && (wb_rd == rs2_addr) && (w_cnt_rs2 == CNT_ONE));
    w_ovf     = issue_wen && (issue_rd != 5'd0) && (w_cnt_rd == CNT_MAX) &&
                !(wb_en && (wb_rd == issue_rd));
  end

  assign issue_ready = !w_src1_hz && !w_src2_hz && !w_ovf;
  assign w_fire      = issue_valid && issue_ready;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus pushes expectations, a negedge monitor checks them.
module tb_regfile_scoreboard;

  localparam int SEL_RS1   = 0;
  localparam int SEL_RS2   = 1;
  localparam int SEL_READY = 2;
  localparam int SEL_BUSY  = 3;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_wen;
  logic        issue_use_rs1;
  logic        issue_use_rs2;
  logic        issue_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [31:0] busy_mask;

  typedef struct {
    int          sel;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;
  bit   stim_done;

  regfile_scoreboard #(.XLEN(64), .CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_wen    (issue_wen),
    .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2),
    .issue_ready  (issue_ready),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .busy_mask    (busy_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    rst           = 1'b0;
    rs1_addr      = 5'd0;
    rs2_addr      = 5'd0;
    issue_valid   = 1'b0;
    issue_rd      = 5'd0;
    issue_wen     = 1'b0;
    issue_use_rs1 = 1'b0;
    issue_use_rs2 = 1'b0;
    wb_en         = 1'b0;
    wb_rd         = 5'd0;
    wb_data       = 64'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic expect_val(input int sel, input logic [63:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_rd    = rd;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [63:0] data);
    wb_en   = 1'b1;
    wb_rd   = rd;
    wb_data = data;
  endtask

  // Monitor: outputs are combinational or post-edge registered, so they are stable at negedge.
  always @(negedge clk) begin
    while (q.size() != 0) begin
      exp_t        e;
      logic [63:0] act;
      e = q.pop_front();
      case (e.sel)
        SEL_RS1:   act = rs1_data;
        SEL_RS2:   act = rs2_data;
        SEL_READY: act = {63'd0, issue_ready};
        default:   act = {32'd0, busy_mask};
      endcase
      n_cmp = n_cmp + 1;
      if (act !== e.exp) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got 0x%016h expected 0x%016h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: 0x%016h", e.name, act);
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    stim_done = 1'b0;
    clear_inputs();
    rst = 1'b1;

    next_cycle(); rst = 1'b1;
    // Reset state
    next_cycle();
    rs1_addr = 5'd5;
    expect_val(SEL_RS1,   64'd0, "reset_rs1");
    expect_val(SEL_RS2,   64'd0, "reset_rs2");
    expect_val(SEL_BUSY,  64'd0, "reset_busy");
    expect_val(SEL_READY, 64'd1, "reset_ready");

    // Write then read back
    next_cycle(); wb(5'd7, 64'hDEADBEEF_00000001);
    next_cycle(); rs1_addr = 5'd7;
    expect_val(SEL_RS1, 64'hDEADBEEF_00000001, "readback_x7");

    // x0 ignores writes and bypass
    next_cycle(); wb(5'd0, 64'hFF);
    expect_val(SEL_RS1, 64'd0, "x0_no_bypass");
    next_cycle();
    expect_val(SEL_RS1, 64'd0, "x0_after_write");

    // Same-cycle bypass
    next_cycle(); wb(5'd3, 64'h1234); rs2_addr = 5'd3;
    expect_val(SEL_RS2, 64'h1234, "bypass_rs2");

    // RAW stall on x4
    next_cycle(); issue(5'd4);
    expect_val(SEL_READY, 64'd1, "issue_rd4_ready");
    next_cycle();
    issue_valid = 1'b1; issue_use_rs1 = 1'b1; rs1_addr = 5'd4;
    expect_val(SEL_READY, 64'd0, "raw_stall");
    expect_val(SEL_BUSY, 64'h10, "busy_x4");
    next_cycle();
    issue_valid = 1'b1; issue_use_rs1 = 1'b1; rs1_addr = 5'd4; wb(5'd4, 64'h55);
    expect_val(SEL_READY, 64'd1, "raw_release");
    expect_val(SEL_RS1, 64'h55, "raw_bypass");
    next_cycle(); rs1_addr = 5'd4;
    expect_val(SEL_BUSY, 64'd0, "busy_x4_clear");
    expect_val(SEL_RS1, 64'h55, "x4_stored");

    // Overflow on x9
    for (int i = 0; i < 3; i++) begin
      next_cycle(); issue(5'd9);
      expect_val(SEL_READY, 64'd1, $sformatf("issue_x9_%0d", i));
    end
    next_cycle(); issue(5'd9);
    expect_val(SEL_READY, 64'd0, "ovf_block");
    expect_val(SEL_BUSY, 64'h200, "busy_x9");
    next_cycle(); issue(5'd9); wb(5'd9, 64'h99);
    expect_val(SEL_READY, 64'd1, "ovf_with_wb");
    next_cycle(); issue(5'd9); rs1_addr = 5'd9;
    expect_val(SEL_READY, 64'd0, "ovf_cnt_still_max");
    expect_val(SEL_RS1, 64'h99, "x9_stored");

    // cnt==3 with a retiring write is still a hazard
    next_cycle();
    issue_valid = 1'b1; issue_use_rs1 = 1'b1; rs1_addr = 5'd9; wb(5'd9, 64'hAA);
    expect_val(SEL_READY, 64'd0, "raw_multi_pending");
    expect_val(SEL_RS1, 64'hAA, "bypass_multi_pending");
    next_cycle();
    expect_val(SEL_BUSY, 64'h200, "busy_x9_after_dec");

    // Reset mid-operation
    next_cycle(); rst = 1'b1;
    next_cycle(); rs1_addr = 5'd9;
    expect_val(SEL_BUSY, 64'd0, "rst_busy_clear");
    expect_val(SEL_RS1, 64'd0, "rst_regs_clear");
    next_cycle(); wb(5'd9, 64'h77);
    next_cycle();
    issue_valid = 1'b1; issue_use_rs1 = 1'b1; rs1_addr = 5'd9;
    expect_val(SEL_BUSY, 64'd0, "drain_cnt_floor");
    expect_val(SEL_RS1, 64'h77, "drain_data_written");
    expect_val(SEL_READY, 64'd1, "drain_no_hazard");

    // rs2 hazard with the single-pending bypass exception
    next_cycle(); issue(5'd9);
    next_cycle();
    issue_valid = 1'b1; issue_use_rs2 = 1'b1; rs2_addr = 5'd9;
    expect_val(SEL_READY, 64'd0, "raw_stall_rs2");
    next_cycle();
    issue_valid = 1'b1; issue_use_rs2 = 1'b1; rs2_addr = 5'd9; wb(5'd9, 64'h88);
    expect_val(SEL_READY, 64'd1, "raw_release_rs2");
    expect_val(SEL_RS2, 64'h88, "raw_bypass_rs2");
    next_cycle();
    expect_val(SEL_BUSY, 64'd0, "busy_x9_final");

    next_cycle();
    next_cycle();
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 1000) begin
      @(posedge clk);
      budget = budget + 1;
    end
    if (!stim_done) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL timeout: got %0d cycles expected stimulus to finish", budget);
    end
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
